// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit - data-bus req/gnt/rvalid handshake,
//                 load alignment/extension and MEM/WB writeback generation.
// Revision 1.0
// ============================================================================
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] exmem_op_c_i,
   input  logic [4:0]  exmem_reg_waddr_i,
   input  logic        exmem_reg_we_i,
   input  logic        exmem_mtype_i,
   input  logic        exmem_mem_rw_i,
   input  logic [1:0]  exmem_mem_width_i,
   input  logic [31:0] exmem_mem_wr_data_i,
   input  logic        exmem_mem_rdtype_i,
   input  logic [31:0] exmem_mem_addr_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [3:0]  dbus_be_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_gnt_i,
   input  logic        dbus_rvalid_i,
   input  logic [31:0] dbus_rdata_i,
   output logic [31:0] mem_reg_wdata_o,
   output logic [4:0]  mem_reg_waddr_o,
   output logic        mem_reg_we_o,
   output logic        mem_stall_req_o,
   output logic        mem_misalign_o,
   output logic        mem_bus_err_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] tcnt, tcnt_nxt;
   logic [1:0]       ld_width, ld_off;
   logic             ld_zext;

   logic        misalign, memop, is_store, timeout, capture;
   logic        req, stall, wb_we, bus_err, mis_pulse;
   logic [31:0] wb_wdata, load_val, lane_wdata;
   logic [3:0]  be;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign misalign = ((exmem_mem_width_i == 2'b01) & exmem_mem_addr_i[0]) |
                     (exmem_mem_width_i[1] & (|exmem_mem_addr_i[1:0]));
   assign memop    = exmem_mtype_i & ~misalign;
   assign is_store = exmem_mem_rw_i;
   assign timeout  = (state != ST_IDLE) && (tcnt == CNT_LAST);

   always_comb begin
      be         = 4'b1111;
      lane_wdata = exmem_mem_wr_data_i;
      case (exmem_mem_width_i)
         2'b00: begin
            be         = 4'b0001 << exmem_mem_addr_i[1:0];
            lane_wdata = {4{exmem_mem_wr_data_i[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << {exmem_mem_addr_i[1], 1'b0};
            lane_wdata = {2{exmem_mem_wr_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane selection uses the attributes captured at grant time.
   always_comb begin
      ld_byte = dbus_rdata_i[7:0];
      case (ld_off)
         2'd1:    ld_byte = dbus_rdata_i[15:8];
         2'd2:    ld_byte = dbus_rdata_i[23:16];
         2'd3:    ld_byte = dbus_rdata_i[31:24];
         default: ;
      endcase
      ld_half  = ld_off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
      load_val = dbus_rdata_i;
      case (ld_width)
         2'b00:   load_val = ld_zext ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   load_val = ld_zext ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = '0;
      req       = 1'b0;
      stall     = 1'b0;
      wb_we     = 1'b0;
      wb_wdata  = exmem_op_c_i;
      bus_err   = 1'b0;
      mis_pulse = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!exmem_mtype_i) begin
               wb_we = exmem_reg_we_i;
            end else if (misalign) begin
               mis_pulse = 1'b1;
            end else begin
               req = 1'b1;
               if (dbus_gnt_i) begin
                  capture = 1'b1;
                  if (!is_store) begin
                     stall     = 1'b1;
                     state_nxt = ST_DATA;
                  end
               end else begin
                  stall     = 1'b1;
                  state_nxt = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            tcnt_nxt = tcnt + 1'b1;
            if (timeout) begin
               bus_err   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               req   = 1'b1;
               stall = 1'b1;
               if (dbus_gnt_i) begin
                  capture = 1'b1;
                  // A store completes in its grant cycle; release the hold so it is not re-issued.
                  if (is_store) begin
                     stall     = 1'b0;
                     state_nxt = ST_IDLE;
                  end else begin
                     state_nxt = ST_DATA;
                  end
               end
            end
         end
         ST_DATA: begin
            tcnt_nxt = tcnt + 1'b1;
            if (timeout) begin
               bus_err   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (dbus_rvalid_i) begin
               wb_we     = exmem_reg_we_i;
               wb_wdata  = load_val;
               state_nxt = ST_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tcnt     <= '0;
         ld_width <= 2'b00;
         ld_off   <= 2'b00;
         ld_zext  <= 1'b0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
         if (capture) begin
            ld_width <= exmem_mem_width_i;
            ld_off   <= exmem_mem_addr_i[1:0];
            ld_zext  <= exmem_mem_rdtype_i;
         end
      end
   end

   // Outputs are forced low for the whole reset assertion, not only after the next edge.
   assign dbus_req_o      = rst_n & req;
   assign dbus_we_o       = rst_n & memop & is_store;
   assign dbus_be_o       = rst_n ? be : 4'b0000;
   assign dbus_addr_o     = rst_n ? {exmem_mem_addr_i[31:2], 2'b00} : 32'b0;
   assign dbus_wdata_o    = rst_n ? lane_wdata : 32'b0;
   assign mem_reg_wdata_o = rst_n ? wb_wdata : 32'b0;
   assign mem_reg_waddr_o = rst_n ? exmem_reg_waddr_i : 5'b0;
   assign mem_reg_we_o    = rst_n & wb_we;
   assign mem_stall_req_o = rst_n & stall;
   assign mem_misalign_o  = rst_n & mis_pulse;
   assign mem_bus_err_o   = rst_n & bus_err;

endmodule
`default_nettype wire
